// File: rtl/seq_det_pkg.sv
// Shared elaboration-time helpers for the serial pattern detectors.
package seq_det_pkg;

   localparam int unsigned MAX_PAT_W = 16;

   // State register width for a detector of pattern length pat_w (never below 1 bit)
   function automatic int unsigned state_w(input int unsigned pat_w);
      return (pat_w <= 2) ? 1 : $clog2(pat_w);
   endfunction

   // Pattern bit in arrival order: index 0 is the first bit received
   function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pattern,
                                    input int unsigned pat_w,
                                    input int unsigned i);
      return pattern[pat_w-1-i];
   endfunction

   // Longest proper prefix of the pattern that is also a suffix
   function automatic int unsigned border_len(input logic [MAX_PAT_W-1:0] pattern,
                                              input int unsigned pat_w);
      int unsigned best;
      logic        ok;
      best = 0;
      for (int unsigned j = 1; j < pat_w; j++) begin
         ok = 1'b1;
         for (int unsigned i = 0; i < j; i++)
            if (pat_bit(pattern, pat_w, i) != pat_bit(pattern, pat_w, pat_w-j+i))
               ok = 1'b0;
         if (ok)
            best = j;
      end
      return best;
   endfunction

   // Matched-prefix length after accepting bit b with k pattern bits already matched
   function automatic int unsigned next_state(input logic [MAX_PAT_W-1:0] pattern,
                                              input int unsigned pat_w,
                                              input int unsigned k,
                                              input logic b,
                                              input logic overlap);
      int unsigned best;
      logic        ok;
      logic        s_bit;
      if (k == pat_w-1 && b == pat_bit(pattern, pat_w, pat_w-1))
         return overlap ? border_len(pattern, pat_w) : 0;
      // s = first k pattern bits followed by b, length k+1
      best = 0;
      for (int unsigned j = 1; j <= k+1; j++) begin
         ok = 1'b1;
         for (int unsigned i = 0; i < j; i++) begin
            s_bit = (k+1-j+i < k) ? pat_bit(pattern, pat_w, k+1-j+i) : b;
            if (s_bit != pat_bit(pattern, pat_w, i))
               ok = 1'b0;
         end
         if (ok)
            best = j;
      end
      return best;
   endfunction

endpackage

// File: rtl/seq_det_counter.sv
// Saturating match counter with sticky saturation flag and synchronous clear.
module seq_det_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   logic [CNT_W-1:0] count_nx;

   // Incremented value, used only when not yet saturated
   always_comb begin
      count_nx = count + CNT_W'(1);
   end

   // Count register: clear wins over increment, hold at all-ones
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         count <= '0;
         sat   <= 1'b0;
      end else if (clr) begin
         count <= '0;
         sat   <= 1'b0;
      end else if (inc && !(&count)) begin
         count <= count_nx;
         if (&count_nx)
            sat <= 1'b1;
      end
   end

endmodule

// File: rtl/seq_detector_mealy.sv
// Parametrised Mealy serial pattern detector with registered match pulse and saturating count.
module seq_detector_mealy
   import seq_det_pkg::*;
#(
   parameter int unsigned           PAT_W   = 4,
   parameter logic [PAT_W-1:0]      PATTERN = 4'b1101,
   parameter logic                  OVERLAP = 1'b1,
   parameter int unsigned           CNT_W   = 8
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             en,
   input  logic             in,
   input  logic             clr,
   output logic             Z,
   output logic [CNT_W-1:0] match_count,
   output logic             sat
);

   localparam int unsigned              SW      = state_w(PAT_W);
   localparam int unsigned              NST     = 2**SW;
   localparam logic [SW-1:0]            S_EMPTY = '0;
   localparam logic [SW-1:0]            S_FULL  = SW'(PAT_W-1);
   localparam logic [MAX_PAT_W-1:0]     PAT_EXT = MAX_PAT_W'(PATTERN);

   logic [SW-1:0] PS;
   logic [SW-1:0] NS;
   logic          Ztemp;
   logic [SW-1:0] ns_tbl0 [NST];
   logic [SW-1:0] ns_tbl1 [NST];

   // Transition table fixed at elaboration; unreachable codes fall back to the empty-state row
   for (genvar g = 0; g < NST; g++) begin : g_tbl
      localparam int unsigned K   = (g < PAT_W) ? g : 0;
      localparam logic [SW-1:0] N0 = SW'(next_state(PAT_EXT, PAT_W, K, 1'b0, OVERLAP));
      localparam logic [SW-1:0] N1 = SW'(next_state(PAT_EXT, PAT_W, K, 1'b1, OVERLAP));
      assign ns_tbl0[g] = N0;
      assign ns_tbl1[g] = N1;
   end

   // Match decode and next matched-prefix length; state holds while en is low
   always_comb begin
      Ztemp = en && (PS == S_FULL) && (in == PATTERN[0]);
      NS    = PS;
      if (en)
         NS = in ? ns_tbl1[PS] : ns_tbl0[PS];
   end

   // State and registered match pulse
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         PS <= S_EMPTY;
         Z  <= 1'b0;
      end else begin
         PS <= NS;
         Z  <= Ztemp;
      end
   end

   seq_det_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .inc     (Ztemp),
      .clr     (clr),
      .count   (match_count),
      .sat     (sat)
   );

endmodule

// File: tb/tb_seq_detector_mealy.sv
// Self-checking bench: three detector variants on one stimulus stream against a sliding-window model.
module tb_seq_detector_mealy;

   localparam logic [3:0] PAT = 4'b1101;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       en, in, clr;
   logic       Z_a, Z_b, Z_c;
   logic [7:0] cnt_a, cnt_b;
   logic [1:0] cnt_c;
   logic       sat_a, sat_b, sat_c;

   int tests = 0;
   int fails = 0;

   always #5 Clk = ~Clk;

   seq_detector_mealy #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_dut_a (
      .Clk(Clk), .Reset_n(Reset_n), .en(en), .in(in), .clr(clr),
      .Z(Z_a), .match_count(cnt_a), .sat(sat_a));

   seq_detector_mealy #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u_dut_b (
      .Clk(Clk), .Reset_n(Reset_n), .en(en), .in(in), .clr(clr),
      .Z(Z_b), .match_count(cnt_b), .sat(sat_b));

   seq_detector_mealy #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)) u_dut_c (
      .Clk(Clk), .Reset_n(Reset_n), .en(en), .in(in), .clr(clr),
      .Z(Z_c), .match_count(cnt_c), .sat(sat_c));

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: window of the last accepted bits; non-overlap mode forgets history after a match
   logic [3:0] m_hist [3];
   int         m_nval [3];
   int         m_cnt  [3];
   logic       m_sat  [3];
   logic       m_z    [3];

   function automatic int m_max(input int i);
      return (i == 2) ? 3 : 255;
   endfunction

   function automatic logic m_ov(input int i);
      return (i != 1);
   endfunction

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < 3; i++) begin
            m_hist[i] <= '0;
            m_nval[i] <= 0;
            m_cnt[i]  <= 0;
            m_sat[i]  <= 1'b0;
            m_z[i]    <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            automatic logic [3:0] h = m_hist[i];
            automatic int         n = m_nval[i];
            automatic int         c = m_cnt[i];
            automatic logic       s = m_sat[i];
            automatic logic       m = 1'b0;
            if (en) begin
               h = {h[2:0], in};
               n = (n < 4) ? n + 1 : 4;
               if (n == 4 && h == PAT) begin
                  m = 1'b1;
                  if (!m_ov(i))
                     n = 0;
               end
            end
            if (clr) begin
               c = 0;
               s = 1'b0;
            end else if (m && c < m_max(i)) begin
               c = c + 1;
            end
            if (c == m_max(i))
               s = 1'b1;
            m_hist[i] <= h;
            m_nval[i] <= n;
            m_cnt[i]  <= c;
            m_sat[i]  <= s;
            m_z[i]    <= m;
         end
      end
   end

   // Every-cycle comparison against the model, away from the rising edge
   always @(negedge Clk) begin
      if (Reset_n) begin
         chk("model Z_a", int'(Z_a), int'(m_z[0]));
         chk("model Z_b", int'(Z_b), int'(m_z[1]));
         chk("model Z_c", int'(Z_c), int'(m_z[2]));
         chk("model cnt_a", int'(cnt_a), m_cnt[0]);
         chk("model cnt_b", int'(cnt_b), m_cnt[1]);
         chk("model cnt_c", int'(cnt_c), m_cnt[2]);
         chk("model sat_a", int'(sat_a), int'(m_sat[0]));
         chk("model sat_b", int'(sat_b), int'(m_sat[1]));
         chk("model sat_c", int'(sat_c), int'(m_sat[2]));
      end
   end

   // Drive n steps (MSB first) and check Z of each variant against hand-written vectors
   task automatic run(input int n, input logic [31:0] bits, input logic [31:0] ens,
                      input logic [31:0] clrs, input logic [31:0] za, input logic [31:0] zb);
      for (int i = n-1; i >= 0; i--) begin
         en  = ens[i];
         in  = bits[i];
         clr = clrs[i];
         @(posedge Clk);
         @(negedge Clk);
         #1;
         chk($sformatf("lit Z_a step %0d", n-1-i), int'(Z_a), int'(za[i]));
         chk($sformatf("lit Z_b step %0d", n-1-i), int'(Z_b), int'(zb[i]));
         chk($sformatf("lit Z_c step %0d", n-1-i), int'(Z_c), int'(za[i]));
      end
      en  = 1'b0;
      clr = 1'b0;
   endtask

   // Asynchronous reset pulse between edges; outputs must clear without a clock
   task automatic do_reset();
      Reset_n = 1'b0;
      #1;
      chk("rst Z_a", int'(Z_a), 0);
      chk("rst Z_b", int'(Z_b), 0);
      chk("rst Z_c", int'(Z_c), 0);
      chk("rst cnt_a", int'(cnt_a), 0);
      chk("rst cnt_c", int'(cnt_c), 0);
      chk("rst sat_c", int'(sat_c), 0);
      #1;
      Reset_n = 1'b1;
   endtask

   initial begin
      Reset_n = 1'b0;
      en      = 1'b0;
      in      = 1'b0;
      clr     = 1'b0;
      repeat (2) @(negedge Clk);
      #1;
      chk("init Z_a", int'(Z_a), 0);
      chk("init cnt_a", int'(cnt_a), 0);
      chk("init sat_a", int'(sat_a), 0);
      chk("init sat_c", int'(sat_c), 0);
      #1;
      Reset_n = 1'b1;

      // Overlap vs non-overlap on 1101101
      run(7, 32'b1101101, 32'h7f, 32'h0, 32'b0001001, 32'b0001000);
      chk("ovl cnt_a", int'(cnt_a), 2);
      chk("novl cnt_b", int'(cnt_b), 1);

      // Failure-function path on 11101
      do_reset();
      run(5, 32'b11101, 32'h1f, 32'h0, 32'b00001, 32'b00001);
      chk("fail-path cnt_a", int'(cnt_a), 1);

      // Reset in the middle of a partial match
      run(3, 32'b110, 32'h7, 32'h0, 32'b000, 32'b000);
      chk("pre-rst cnt_a", int'(cnt_a), 1);
      do_reset();
      run(5, 32'b11101, 32'h1f, 32'h0, 32'b00001, 32'b00001);
      chk("post-rst cnt_a", int'(cnt_a), 1);

      // Enable gating: 1,1, (en=0 in=0), (en=0 in=1), 0,1
      do_reset();
      run(6, 32'b110101, 32'b110011, 32'h0, 32'b000001, 32'b000001);
      chk("gate cnt_a", int'(cnt_a), 1);

      // Saturation of the 2-bit counter over five matches
      do_reset();
      run(20, 32'b1101_1101_1101_1101_1101, 32'hfffff, 32'h0,
          32'b0001_0001_0001_0001_0001, 32'b0001_0001_0001_0001_0001);
      chk("sat cnt_c", int'(cnt_c), 3);
      chk("sat sat_c", int'(sat_c), 1);
      chk("sat cnt_a", int'(cnt_a), 5);
      chk("sat sat_a", int'(sat_a), 0);

      // clr on the edge of a match: pulse survives, count does not
      run(4, 32'b1101, 32'hf, 32'b0001, 32'b0001, 32'b0001);
      chk("clr cnt_c", int'(cnt_c), 0);
      chk("clr sat_c", int'(sat_c), 0);
      chk("clr cnt_a", int'(cnt_a), 0);

      // Randomised traffic with occasional clear and asynchronous reset
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0)
            do_reset();
         en  = ($urandom_range(0, 3) != 0);
         in  = $urandom_range(0, 1) == 1;
         clr = ($urandom_range(0, 39) == 0);
         @(posedge Clk);
         @(negedge Clk);
         #1;
      end
      en  = 1'b0;
      clr = 1'b0;
      @(negedge Clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_detector_mealy.md
# seq_detector_mealy

Parametrised Mealy-type serial pattern detector. It tracks a one-bit input stream sampled under an enable and flags each occurrence of a compile-time pattern with a registered one-cycle pulse. It keeps a saturating count of matches. It sits beside the other state-machine blocks as the general-purpose successor to the fixed two-state detectors: pattern width, pattern value and overlap mode are all parameters, and it adds enable gating, match counting and saturation.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101: pattern value, PAT_W bits. PATTERN[PAT_W-1] is the first bit received.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = detector restarts from empty after a match.
- CNT_W, 8: width of the match counter.
- Clk  input  1  single clock; all state changes on its rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; `in` is consumed only when en=1.
- in  input  1  serial data bit.
- clr  input  1  synchronous clear of match_count and sat; the FSM is unaffected.
- Z  output  1  registered match pulse.
- match_count  output  CNT_W  number of matches since reset/clr; saturating.
- sat  output  1  high once match_count has reached all-ones; sticky until clr or reset.

## Operation
- State register PS holds the matched-prefix length k, range 0..PAT_W-1; width is $clog2(PAT_W).
  - k means the last k accepted bits equal PATTERN[PAT_W-1 -: k].
- Next-state rule (KMP failure function), evaluated only when en=1:
  - Let s = the first k pattern bits followed by `in`.
  - NS = the longest j ≤ k+1 such that the last j bits of s equal the first j pattern bits.
  - The table is computed at elaboration; it is never built in hardware at run time.
- Match condition, combinational (Ztemp): en=1 AND k=PAT_W-1 AND in=PATTERN[0].
- On a match:
  - NS = border(PAT_W) when OVERLAP=1, where border(PAT_W) is the longest proper prefix of PATTERN that is also a suffix.
  - NS = 0 when OVERLAP=0.
- en=0: PS holds, Ztemp=0, `in` is ignored.
- Counter behaviour:
  - A match increments match_count unless it is already all-ones.
  - sat is set when match_count becomes all-ones.
  - clr has priority over a simultaneous match: the result is match_count=0 and sat=0, and the match is not counted.
- Reset (Reset_n=0) forces PS=0, Z=0, match_count=0 and sat=0 immediately, independent of Clk. This applies mid-pattern too: any partial match is discarded.
- After Reset_n deasserts, the first rising edge with en=1 samples the first bit.

## Timing
- Z is a registered Mealy output. It is high for exactly one cycle, starting at the rising edge that samples the final pattern bit with en=1.
- Latency from final bit to Z is 1 clock edge.
- match_count updates on the same edge as Z rises.
- Back-to-back matches (OVERLAP=1, periodic pattern) produce Z high on consecutive cycles. There is no minimum gap.
- A clr asserted on the edge of a match leaves Z=1 for that cycle but match_count=0.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

## Structure
- Shared package seq_det_pkg holds:
  - function next_state(pattern, pat_w, k, bit, overlap), used at elaboration;
  - function border_len(pattern, pat_w);
  - localparam helper for the state width.
- Sub-module seq_det_counter: CNT_W saturating counter with inc, clr, count and sat. It is reused by other detectors.
- The top level contains PS/NS logic, the Ztemp decode, the Z register and one seq_det_counter instance.

## Test plan
All scenarios use the defaults (PATTERN=1101, PAT_W=4) unless stated otherwise.
- Async reset:
  - Stimulus: drive Reset_n low between clock edges in the middle of the pattern, after accepting 1,1,0.
  - Response: Z=0, match_count=0 and sat=0 immediately. After release, the stream 1 then 1101 gives exactly one Z, after the 5th bit.
- Overlap:
  - Stimulus: OVERLAP=1, stream 1101101 with en=1.
  - Response: Z pulses after bit 4 and after bit 7; match_count=2.
- Non-overlap:
  - Stimulus: OVERLAP=0, same stream 1101101.
  - Response: Z pulses after bit 4 only; match_count=1.
- Failure-function path:
  - Stimulus: stream 11101.
  - Response: k goes 1, 2, 2, 3, then a match; Z pulses after bit 5; there is no Z earlier.
- Enable gating:
  - Stimulus: bits 1,1 with en=1; two cycles of en=0 with in=0 and in=1; then 0,1 with en=1.
  - Response: one Z after the final 1; Z=0 during the en=0 cycles.
- Saturation and clr:
  - Stimulus: CNT_W=2, five matches.
  - Response: match_count=3 and sat=1 after the third match; both stay there.
  - Stimulus: then clr coincident with a match.
  - Response: Z=1 for that cycle; match_count=0; sat=0.
